click_countdown: RTL

//   Down-counting click tracker: the decrement side of the KEY click-counting path.

---
 rtl/click_pkg.sv | 18 +
 rtl/fourbit_subtractor.sv | 30 +++
 rtl/click_countdown.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/click_pkg.sv
// Shared definitions for the KEY click-counting path (up- and down-count trackers).
//   state_t        : debounce FSM state encoding
//   DEF_WIDTH      : default count width
//   DEF_DEBOUNCE_CYCLES / DEF_DB_W : default debounce window and counter width (10 ms @ 50 MHz)
package click_pkg;

  localparam int unsigned DEF_WIDTH           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_DB_W            = 20;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/fourbit_subtractor.sv
// Four-bit ripple subtractor built from full subtractors: diff = a - b - bin.
// Ports:
//   a, b  in  4  minuend, subtrahend
//   bin   in  1  borrow in
//   diff  out 4  difference (modulo 16)
//   bout  out 1  borrow out (set when a < b + bin)
module fourbit_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] br;

  // Bit-serial borrow ripple
  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int i = 0; i < 4; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end

  assign bout = br[4];

endmodule

// File: rtl/click_countdown.sv
// Down-counting click tracker: synchronises and debounces an active-low push-button,
// emits one click per accepted press and decrements a loadable count on each click.
// Ports:
//   CLOCK_50  in   1      clock, rising edge
//   reset     in   1      synchronous, active-high
//   key_n     in   1      raw push-button, active-low, asynchronous
//   load      in   1      load count from load_val (wins over a click)
//   load_val  in   WIDTH  value to load
//   count     out  WIDTH  current count (registered)
//   zero      out  1      count == 0 (decoded from the count register)
//   borrow    out  1      1-cycle pulse: click applied while count was 0
//   click     out  1      1-cycle pulse: debounced press accepted (state-decoded)
// Build option: define CLICK_SAT_EN to saturate the count at 0 instead of wrapping;
// borrow still flags the underflow attempt.
module click_countdown
  import click_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DB_W            = DEF_DB_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             click
);

  localparam int unsigned NSEG  = (WIDTH + 3) / 4;
  localparam int unsigned PAD_W = NSEG * 4;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            key_m, key_s;
  state_t          state, state_nx;
  logic [DB_W-1:0] db_cnt;
  logic            db_clr, db_done;

  logic [PAD_W-1:0] sub_a, sub_b, sub_d;
  logic [NSEG:0]    sub_br;
  logic [WIDTH-1:0] dec_val;
  logic             underflow;
  logic             unused_sub_hi;

  // Two-flop synchroniser, released (high) out of reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Debounce counter: cleared on entry to a wait state, counts while waiting
  assign db_done = (db_cnt == DB_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      db_cnt <= '0;
    else if (db_clr)
      db_cnt <= '0;
    else if (state == PRESS_WAIT || state == RELEASE_WAIT)
      db_cnt <= db_cnt + DB_W'(1);
  end

  // Next-state and click decode; click is suppressed while reset discards it
  always_comb begin
    state_nx = state;
    db_clr   = 1'b0;
    click    = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nx = PRESS_WAIT;
          db_clr   = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_nx = IDLE;
        end else if (db_done) begin
          state_nx = HELD;
          click    = ~reset;
        end
      end
      HELD: begin
        if (key_s) begin
          state_nx = RELEASE_WAIT;
          db_clr   = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s)       state_nx = HELD;
        else if (db_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // count - 1 through chained four-bit ripple subtractors (zero-padded to a nibble multiple)
  assign sub_a     = PAD_W'(count);
  assign sub_b     = PAD_W'(1);
  assign sub_br[0] = 1'b0;

  for (genvar g = 0; g < NSEG; g++) begin : g_sub
    fourbit_subtractor u_sub (
      .a    (sub_a[4*g +: 4]),
      .b    (sub_b[4*g +: 4]),
      .bin  (sub_br[g]),
      .diff (sub_d[4*g +: 4]),
      .bout (sub_br[g+1])
    );
  end

  assign dec_val       = sub_d[WIDTH-1:0];
  assign underflow     = sub_br[NSEG];
  assign unused_sub_hi = ^sub_d;

  // Count register: load beats click; borrow flags a click taken at zero
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (click) begin
`ifdef CLICK_SAT_EN
        count  <= underflow ? '0 : dec_val;
`else
        count  <= dec_val;
`endif
        borrow <= underflow;
      end
    end
  end

  assign zero = (count == '0);

endmodule
